// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC sequencing, req/ack fetch from program memory,
// and opcode/operand split of each 8-bit instruction word.
module ins_fetch #(
  parameter int unsigned   AW        = 8,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [3:0]    NOP_CODE  = 4'hE,
  parameter logic [3:0]    HALT_CODE = 4'hF
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] mem_addr,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [7:0]    mem_data,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  output logic [3:0]    ins,
  output logic [3:0]    operand,
  output logic          ins_valid,
  output logic [AW-1:0] pc,
  output logic          halted
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    EXEC,
    HALT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_nxt;
  logic [7:0]    ir;
  logic [7:0]    ir_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pc_q  <= RESET_PC;
      ir    <= {NOP_CODE, 4'h0};
    end else begin
      state <= state_nxt;
      pc_q  <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    ir_nxt    = ir;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (mem_ack) begin
          ir_nxt    = mem_data;
          pc_nxt    = pc_q + AW'(1);
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        // a jump overrides the increment taken on the fetch edge
        if (jump) pc_nxt = jump_addr;
        if (ir[7:4] == HALT_CODE) state_nxt = HALT;
        else state_nxt = REQ;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs decode registered state only; no input-to-output paths
  assign mem_req   = (state == REQ);
  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign ins_valid = (state == EXEC);
  assign halted    = (state == HALT);
  assign ins       = ins_valid ? ir[7:4] : NOP_CODE;
  assign operand   = ins_valid ? ir[3:0] : 4'h0;

endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: memory model with wait states,
// scoreboard of fetched words, cycle tables and corner-case sequences.
module tb_ins_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic       jump = 1'b0;
  logic [7:0] jump_addr = 8'h00;
  logic [3:0] ins;
  logic [3:0] operand;
  logic       ins_valid;
  logic [7:0] pc;
  logic       halted;

  logic [7:0] w_addr;
  logic       w_req;
  logic       w_ack = 1'b1;
  logic [7:0] w_data = 8'h31;
  logic       w_jump = 1'b0;
  logic [7:0] w_jaddr = 8'h00;
  logic [3:0] w_ins;
  logic [3:0] w_op;
  logic       w_valid;
  logic [7:0] w_pc;
  logic       w_halted;

  ins_fetch u_dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_data(mem_data),
    .jump(jump), .jump_addr(jump_addr),
    .ins(ins), .operand(operand),
    .ins_valid(ins_valid), .pc(pc),
    .halted(halted)
  );

  ins_fetch #(.RESET_PC(8'hFF)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(w_addr), .mem_req(w_req),
    .mem_ack(w_ack), .mem_data(w_data),
    .jump(w_jump), .jump_addr(w_jaddr),
    .ins(w_ins), .operand(w_op),
    .ins_valid(w_valid), .pc(w_pc),
    .halted(w_halted)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  logic [7:0] mem [256];
  int   wait_n     = 0;
  logic ack_always = 1'b0;
  logic jump_other = 1'b0;
  logic jump_exec  = 1'b0;
  logic rnd_in     = 1'b0;
  int   wcnt       = 0;

  typedef struct {
    logic [3:0] ins;
    logic [3:0] op;
    logic [7:0] pc;
  } exp_t;
  exp_t sb[$];

  // memory model, jump driver and scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      wcnt = 0;
      if (rnd_in) begin
        mem_ack   = 1'($urandom);
        mem_data  = 8'($urandom);
        jump      = 1'($urandom);
        jump_addr = 8'($urandom);
      end else begin
        mem_ack   = ack_always;
        mem_data  = mem[mem_addr];
        jump      = 1'b0;
        jump_addr = 8'h00;
      end
    end else begin
      if (ins_valid) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("sb_ins", ins, e.ins);
          chk("sb_operand", operand, e.op);
          chk("sb_pc", pc, e.pc);
        end
      end
      if (mem_req) begin
        mem_ack = ack_always || (wcnt == wait_n);
        wcnt++;
      end else begin
        mem_ack = ack_always;
        wcnt = 0;
      end
      mem_data = mem[mem_addr];
      if (mem_req && mem_ack) begin
        e.ins = mem_data[7:4];
        e.op  = mem_data[3:0];
        e.pc  = mem_addr + 8'd1;
        sb.push_back(e);
      end
      jump      = ins_valid ? (jump_exec && ins == 4'h4) : jump_other;
      jump_addr = ins_valid ? 8'h40 : 8'h99;
    end
  end

  task automatic do_reset(input int wn, input logic aa,
                          input logic jo, input logic je);
    rst_n      = 1'b0;
    rnd_in     = 1'b0;
    wait_n     = wn;
    ack_always = aa;
    jump_other = jo;
    jump_exec  = je;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic       req;
    logic [7:0] addr;
    logic       valid;
    logic [3:0] ins;
    logic [3:0] op;
    logic [7:0] pc;
  } vec_t;
  vec_t tv[6];

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
    tv[0] = '{1'b0, 8'h00, 1'b0, 4'hE, 4'h0, 8'h00};
    tv[1] = '{1'b1, 8'h00, 1'b0, 4'hE, 4'h0, 8'h00};
    tv[2] = '{1'b0, 8'h01, 1'b1, 4'h2, 4'h5, 8'h01};
    tv[3] = '{1'b1, 8'h01, 1'b0, 4'hE, 4'h0, 8'h01};
    tv[4] = '{1'b0, 8'h02, 1'b1, 4'h1, 4'h3, 8'h02};
    tv[5] = '{1'b1, 8'h02, 1'b0, 4'hE, 4'h0, 8'h02};

    // reset with random inputs
    rnd_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_pc", pc, 8'h00);
      chk("rst_addr", mem_addr, 8'h00);
      chk("rst_req", mem_req, 0);
      chk("rst_ins", ins, 4'hE);
      chk("rst_operand", operand, 0);
      chk("rst_valid", ins_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_wrap_pc", w_pc, 8'hFF);
    end

    // straight line, zero wait, ack tied high
    mem[0] = 8'h25;
    mem[1] = 8'h13;
    do_reset(0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("sl_req", mem_req, tv[i].req);
      if (tv[i].req) chk("sl_addr", mem_addr, tv[i].addr);
      chk("sl_valid", ins_valid, tv[i].valid);
      chk("sl_ins", ins, tv[i].ins);
      chk("sl_operand", operand, tv[i].op);
      chk("sl_pc", pc, tv[i].pc);
      if (i == 2) begin
        chk("wrap_valid", w_valid, 1);
        chk("wrap_pc", w_pc, 8'h00);
        chk("wrap_ins", w_ins, 4'h3);
      end
      if (i == 3) begin
        chk("wrap_req", w_req, 1);
        chk("wrap_addr", w_addr, 8'h00);
      end
    end

    // three wait states at address 0
    do_reset(3, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 chk("ws_idle", mem_req, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      #1;
      chk("ws_req", mem_req, 1);
      chk("ws_addr", mem_addr, 8'h00);
      chk("ws_novalid", ins_valid, 0);
    end
    @(negedge clk);
    #1;
    chk("ws_valid", ins_valid, 1);
    chk("ws_ins", ins, 4'h2);
    @(negedge clk);
    #1 chk("ws_single", ins_valid, 0);

    // jump from 0x05; jump held high outside EXEC must be ignored
    for (int i = 0; i < 5; i++) mem[i] = 8'h10 + 8'(i);
    mem[5]    = 8'h4A;
    mem[8'h40] = 8'h77;
    do_reset(1, 1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      #1;
      if (ins_valid && ins == 4'h4) found = 1'b1;
    end
    chk("jmp_reached", 32'(found), 1);
    chk("jmp_exec_pc", pc, 8'h06);
    chk("jmp_operand", operand, 4'hA);
    @(negedge clk);
    #1;
    chk("jmp_req", mem_req, 1);
    chk("jmp_addr", mem_addr, 8'h40);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      #1;
      if (ins_valid) found = 1'b1;
    end
    chk("jmp_target_fetch", 32'(found), 1);
    chk("jmp_target_ins", ins, 4'h7);
    chk("jmp_target_pc", pc, 8'h41);

    // halt
    mem[0] = 8'hF0;
    do_reset(0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("halt_valid", ins_valid, 1);
    chk("halt_ins", ins, 4'hF);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      #1;
      chk("halt_flag", halted, 1);
      chk("halt_req", mem_req, 0);
      chk("halt_novalid", ins_valid, 0);
      chk("halt_pc", pc, 8'h01);
      chk("halt_nop", ins, 4'hE);
    end

    // reset dropped mid-request, late ack ignored
    mem[0] = 8'h25;
    do_reset(5, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 chk("mr_req_before", mem_req, 1);
    #2;
    rst_n      = 1'b0;
    ack_always = 1'b1;
    #1 chk("mr_req_async", mem_req, 0);
    repeat (2) @(negedge clk);
    ack_always = 1'b0;
    wait_n     = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_idle_req", mem_req, 0);
    chk("mr_idle_pc", pc, 8'h00);
    @(negedge clk);
    #1;
    chk("mr_req", mem_req, 1);
    chk("mr_addr", mem_addr, 8'h00);
    @(negedge clk);
    #1;
    chk("mr_valid", ins_valid, 1);
    chk("mr_ins", ins, 4'h2);
    chk("mr_operand", operand, 4'h5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
